im_loader: RTL and testbench
============================

# im_loader

Boot-time writer for the instruction memory. Receives a byte stream over a valid/ready handshake, assembles 32-bit instruction words MSB-first, and drives the instruction memory write port at consecutive word addresses from 0. The pipeline is held in reset-like stall while a load is in progress. This replaces the file-based initial image for hardware bring-up.

## Interface
- PC_SIZE, 11, width of the word address driven to the instruction memory
- INSTR_SIZE, 32, instruction word width (fixed at 32; four bytes per word)
- ROM_CAPACITY, 256, maximum number of words accepted
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load from IDLE or DONE, ignored otherwise
- rx_data  input  8  stream byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte this cycle
- im_we  output  1  instruction memory write strobe, one cycle per word
- im_waddr  output  PC_SIZE  word address for the write
- im_wdata  output  INSTR_SIZE  word to write
- cpu_hold  output  1  pipeline stall/hold while loading
- done  output  1  load finished (sticky until next start or reset)
- err  output  1  load failed (sticky until next start or reset)

## Operation
- Handshake: a byte transfers on a rising edge where rx_valid and rx_ready are both 1. rx_data must be stable while rx_valid is high and rx_ready is low.
- States: IDLE, HDR_HI, HDR_LO, DATA, CHK (only with checksum), DONE.
- IDLE/DONE: rx_ready=0, cpu_hold=0. start -> HDR_HI, clears done, err, word counter, byte counter.
- HDR_HI/HDR_LO: accept two bytes forming a 16-bit word count N, high byte first.
- After HDR_LO: N=0 -> DONE (or CHK); N>ROM_CAPACITY -> err=1, DONE, no writes; otherwise DATA.
- DATA: 2-bit byte counter; bytes shift into a 32-bit register, first byte lands in bits 31:24. On the 4th byte, register word, address = word counter, pulse im_we next cycle, increment word counter. After word N -> DONE (or CHK).
- rx_ready is 1 in HDR_HI, HDR_LO, DATA, CHK; 0 otherwise, including the im_we cycle is not a stall (ready stays high).
- cpu_hold = 1 in HDR_HI, HDR_LO, DATA, CHK.
- start outside IDLE/DONE: ignored.
- Reset mid-load: all state returns to IDLE immediately; words already written remain in memory; done=0, err=0.

## Timing
- Reset values: rx_ready=0, im_we=0, im_waddr=0, im_wdata=0, cpu_hold=0, done=0, err=0, state IDLE.
- start sampled at edge T -> rx_ready and cpu_hold high from T+1.
- 4th byte of word k accepted at edge T -> im_we=1, im_waddr=k, im_wdata=word during cycle T..T+1 (one cycle only); im_waddr/im_wdata hold value afterwards.
- Final data byte at edge T (no checksum) -> done=1 and cpu_hold=0 from T, concurrent with last im_we pulse.
- Minimum load time with rx_valid held high: 2 + 4N cycles (+1 with checksum).
- Word counter is PC_SIZE+1 bits so that N=ROM_CAPACITY completes without wrap; im_waddr = low PC_SIZE bits.

## Configuration
- IM_LOADER_CHECKSUM_EN defined: after data (or after header when N=0), state CHK accepts one byte; it must equal XOR of all data bytes (0x00 when N=0). Mismatch -> err=1; either way -> DONE. done asserted the edge the checksum byte is accepted.
- Not defined: CHK state and XOR accumulator absent; DATA goes straight to DONE.

## Structure
- Shared package: state encoding constants, BYTES_PER_WORD=4, header width 16.
- One sub-module natural: im_loader_word_asm (byte counter + shift register, emits word-valid pulse). FSM, counters and outputs stay in im_loader.

## Test plan
- Load N=2, bytes 00 02 | 24 08 00 05 | 20 09 00 0A, valid always high -> im_we pulses twice: addr 0 data 0x24080005, addr 1 data 0x2009000A; done=1 after 10 accepted bytes; cpu_hold high exactly 10 cycles.
- Header N=0 -> no im_we, done=1 immediately after second header byte (checksum build: after checksum byte 0x00, err=0).
- Header N=257 (01 01) -> err=1, done=1, no im_we, rx_ready drops.
- rx_valid toggling every other cycle over same N=2 stream -> identical writes, load spans ~20 cycles.
- rst_n asserted after 6 bytes of the N=2 stream -> all outputs reset values instantly; new start plus full stream reloads correctly.
- Checksum build: N=1 word DE AD BE EF, checksum byte 0x22 -> err=0; checksum 0x23 -> err=1, word still written at addr 0.

Source files
------------

// File: rtl/im_loader_pkg.sv
//------------------------------------------------------------------------------
// im_loader_pkg
//   Shared constants for the instruction-memory boot loader: byte/word
//   geometry, header width and the loader state encoding.
//   Optional feature macro: IM_LOADER_CHECKSUM_EN (enables the CHK state).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package im_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int HDR_W          = 16;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HDR_HI = 3'd1;
  localparam state_t ST_HDR_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_CHK    = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/im_loader_word_asm.sv
//------------------------------------------------------------------------------
// im_loader_word_asm
//   Assembles bytes MSB-first into instruction words. The word is presented
//   combinationally together with a one-cycle word-valid strobe in the cycle
//   the last byte of the word is accepted.
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     clr_i          restart assembly at byte 0
//     byte_vld_i     a byte is accepted this cycle
//     byte_i         the byte
//     word_vld_o     this byte completes a word
//     word_o         completed word (valid with word_vld_o)
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module im_loader_word_asm
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int              CNT_W    = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]         cnt_q;
  // Only the first three bytes need storage; the fourth is taken straight
  // from the input when the word completes.
  logic [WORD_W-BYTE_W-1:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (byte_vld_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
      sh_q  <= {sh_q[WORD_W-2*BYTE_W-1:0], byte_i};
    end
  end

  assign word_vld_o = byte_vld_i && (cnt_q == CNT_LAST);
  assign word_o     = {sh_q, byte_i};

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
//------------------------------------------------------------------------------
// im_loader
//   Boot-time instruction memory writer. Receives a byte stream (16-bit word
//   count header, high byte first, then words MSB-first) and writes each
//   word at consecutive addresses from 0 while holding the CPU.
//   Optional feature macro: IM_LOADER_CHECKSUM_EN - a trailing XOR checksum
//   byte is required and checked.
//   Ports:
//     clk, rst_n                clock, async active-low reset
//     start_i                   begin a load (from IDLE/DONE only)
//     rx_data_i/rx_valid_i      byte stream in
//     rx_ready_o                byte accepted when rx_valid_i is high
//     im_we_o/im_waddr_o/im_wdata_o  instruction memory write port
//     cpu_hold_o                pipeline hold while loading
//     done_o, err_o             sticky load status
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module im_loader
  import im_loader_pkg::*;
#(
  parameter int PC_SIZE      = 11,
  parameter int INSTR_SIZE   = 32,
  parameter int ROM_CAPACITY = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BYTE_W-1:0]     rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  im_we_o,
  output logic [PC_SIZE-1:0]    im_waddr_o,
  output logic [INSTR_SIZE-1:0] im_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  err_o
);

  // One extra bit so a full ROM_CAPACITY load does not wrap the counter.
  localparam int WC_W = PC_SIZE + 1;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t ST_POST = ST_CHK;
`else
  localparam state_t ST_POST = ST_DONE;
`endif

  state_t                  state_q, state_d;
  logic [BYTE_W-1:0]       hdr_hi_q;
  logic [HDR_W-1:0]        n_q;
  logic [WC_W-1:0]         wcnt_q;
  logic                    im_we_q;
  logic [PC_SIZE-1:0]      im_waddr_q;
  logic [INSTR_SIZE-1:0]   im_wdata_q;
  logic                    err_q;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]       csum_q;
`endif

  logic                    w_busy;
  logic                    w_done;
  logic                    w_acc;
  logic                    w_start;
  logic [HDR_W-1:0]        w_n;
  logic                    w_oversize;
  logic                    w_word_vld;
  logic [WORD_W-1:0]       w_word;
  logic                    w_last;

  assign w_acc      = rx_valid_i && w_busy;
  assign w_start    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign w_n        = {hdr_hi_q, rx_data_i};
  assign w_oversize = 32'(w_n) > 32'(ROM_CAPACITY);
  assign w_last     = (32'(wcnt_q) + 32'd1) == 32'(n_q);

  im_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (w_start),
    .byte_vld_i (w_acc && (state_q == ST_DATA)),
    .byte_i     (rx_data_i),
    .word_vld_o (w_word_vld),
    .word_o     (w_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (w_start) state_d = ST_HDR_HI;
      ST_HDR_HI:        if (w_acc) state_d = ST_HDR_LO;
      ST_HDR_LO: begin
        if (w_acc) begin
          if (w_n == '0)      state_d = ST_POST;
          else if (w_oversize) state_d = ST_DONE;
          else                 state_d = ST_DATA;
        end
      end
      ST_DATA:          if (w_word_vld && w_last) state_d = ST_POST;
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CHK:           if (w_acc) state_d = ST_DONE;
`endif
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (state_q)
      ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHK: w_busy = 1'b1;
      ST_DONE:                               w_done = 1'b1;
      default:                               ;
    endcase
  end

  // Datapath: header, counters, write port, status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_hi_q   <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      im_we_q    <= 1'b0;
      im_waddr_q <= '0;
      im_wdata_q <= '0;
      err_q      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      im_we_q <= w_word_vld;
      if (w_start) begin
        wcnt_q <= '0;
        err_q  <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
      end
      if (w_acc && (state_q == ST_HDR_HI)) hdr_hi_q <= rx_data_i;
      if (w_acc && (state_q == ST_HDR_LO)) begin
        n_q <= w_n;
        if (w_oversize) err_q <= 1'b1;
      end
      if (w_word_vld) begin
        im_waddr_q <= wcnt_q[PC_SIZE-1:0];
        im_wdata_q <= w_word;
        wcnt_q     <= wcnt_q + WC_W'(1);
      end
`ifdef IM_LOADER_CHECKSUM_EN
      if (w_acc && (state_q == ST_DATA)) csum_q <= csum_q ^ rx_data_i;
      if (w_acc && (state_q == ST_CHK) && (rx_data_i != csum_q)) err_q <= 1'b1;
`endif
    end
  end

  assign rx_ready_o = w_busy;
  assign cpu_hold_o = w_busy;
  assign done_o     = w_done;
  assign err_o      = err_q;
  assign im_we_o    = im_we_q;
  assign im_waddr_o = im_waddr_q;
  assign im_wdata_o = im_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
//------------------------------------------------------------------------------
// tb_im_loader
//   Self-checking bench for im_loader: cycle-by-cycle vector table plus
//   hand sequences for throttled input, mid-load reset and checksum.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        im_we_o;
  logic [10:0] im_waddr_o;
  logic [31:0] im_wdata_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  logic [10:0] qa[$];
  logic [31:0] qd[$];

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [10:0] a;
    logic [31:0] w;
    logic        hold;
    logic        dn;
    logic        er;
  } vec_t;
  vec_t tbl[$];

  localparam logic [31:0] W0 = 32'h24080005;
  localparam logic [31:0] W1 = 32'h2009000A;
  logic [7:0] s2 [10] = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                          8'h20, 8'h09, 8'h00, 8'h0A};

  im_loader #(.PC_SIZE(11), .INSTR_SIZE(32), .ROM_CAPACITY(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .im_we_o    (im_we_o),
    .im_waddr_o (im_waddr_o),
    .im_wdata_o (im_wdata_o),
    .cpu_hold_o (cpu_hold_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] outs();
    return {rx_ready_o, im_we_o, im_waddr_o, im_wdata_o, cpu_hold_o, done_o, err_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
  task automatic step(input logic s, input logic v, input logic [7:0] d);
    start_i    = s;
    rx_valid_i = v;
    rx_data_i  = d;
    @(posedge clk);
    #1;
    if (im_we_o) begin
      qa.push_back(im_waddr_o);
      qd.push_back(im_wdata_o);
    end
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [10:0] a,
                     input logic [31:0] w, input logic hold, input logic dn,
                     input logic er);
    vec_t e;
    e.s = s; e.v = v; e.d = d; e.rdy = rdy; e.we = we; e.a = a; e.w = w;
    e.hold = hold; e.dn = dn; e.er = er;
    tbl.push_back(e);
  endtask

  task automatic check_n2_writes(input string tag);
    check({tag, "_nwr"}, 64'(qa.size()), 64'd2);
    if (qa.size() == 2) begin
      check({tag, "_a0"}, 64'(qa[0]), 64'd0);
      check({tag, "_d0"}, 64'(qd[0]), 64'(W0));
      check({tag, "_a1"}, 64'(qa[1]), 64'd1);
      check({tag, "_d1"}, 64'(qd[1]), 64'(W1));
    end
  endtask

  task automatic send_n2_full();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, s2[i]);
`ifdef IM_LOADER_CHECKSUM_EN
    step(1'b0, 1'b1, 8'h0A);
`endif
  endtask

  initial begin
    // ---- N=2 load, valid held high, from IDLE ----
    add(1, 0, 8'h00, 1, 0, 11'd0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 11'd0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h02, 1, 0, 11'd0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h24, 1, 0, 11'd0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h08, 1, 0, 11'd0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 11'd0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h05, 1, 1, 11'd0, W0,    1, 0, 0);
    add(0, 1, 8'h20, 1, 0, 11'd0, W0,    1, 0, 0);
    add(0, 1, 8'h09, 1, 0, 11'd0, W0,    1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 11'd0, W0,    1, 0, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    add(0, 1, 8'h0A, 1, 1, 11'd1, W1,    1, 0, 0);
    add(0, 1, 8'h0A, 0, 0, 11'd1, W1,    0, 1, 0);
`else
    add(0, 1, 8'h0A, 0, 1, 11'd1, W1,    0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 11'd1, W1,    0, 1, 0);
`endif
    // ---- N=0 from DONE: start clears done ----
    add(1, 0, 8'h00, 1, 0, 11'd1, W1,    1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 11'd1, W1,    1, 0, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    add(0, 1, 8'h00, 1, 0, 11'd1, W1,    1, 0, 0);
    add(0, 1, 8'h00, 0, 0, 11'd1, W1,    0, 1, 0);
`else
    add(0, 1, 8'h00, 0, 0, 11'd1, W1,    0, 1, 0);
`endif
    // ---- N=257: oversize -> err, done, no writes, ready drops ----
    add(1, 0, 8'h00, 1, 0, 11'd1, W1,    1, 0, 0);
    add(0, 1, 8'h01, 1, 0, 11'd1, W1,    1, 0, 0);
    add(0, 1, 8'h01, 0, 0, 11'd1, W1,    0, 1, 1);
    add(0, 1, 8'h55, 0, 0, 11'd1, W1,    0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 11'd1, W1,    0, 1, 1);

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_state", 64'(outs()), 64'd0);

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].d);
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({tbl[i].rdy, tbl[i].we, tbl[i].a, tbl[i].w,
                 tbl[i].hold, tbl[i].dn, tbl[i].er}));
    end
    check("table_writes", 64'(qa.size()), 64'd2);

    // ---- throttled stream with ignored start pulses ----
    qa.delete(); qd.delete();
    step(1'b1, 1'b0, 8'h00);
    check("start_clears_err", 64'({err_o, done_o, cpu_hold_o}), 64'b001);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, s2[i]);
      if (i != 9) step(1'b1, 1'b0, 8'h00);
    end
`ifdef IM_LOADER_CHECKSUM_EN
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h0A);
`endif
    check("toggle_done", 64'({done_o, err_o, rx_ready_o, cpu_hold_o}), 64'b1000);
    check_n2_writes("toggle");

    // ---- reset after 6 bytes, then reload ----
    qa.delete(); qd.delete();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, s2[i]);
    check("pre_reset_busy", 64'({cpu_hold_o, im_we_o, done_o}), 64'b110);
    #1 rst_n = 1'b0;
    #1 check("reset_async", 64'(outs()), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_reset_idle", 64'(outs()), 64'd0);
    qa.delete(); qd.delete();
    send_n2_full();
    check("reload_done", 64'({done_o, err_o, cpu_hold_o}), 64'b100);
    check_n2_writes("reload");

`ifdef IM_LOADER_CHECKSUM_EN
    // ---- checksum good / bad ----
    for (int k = 0; k < 2; k++) begin
      logic [7:0] w1 [6];
      w1 = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      qa.delete(); qd.delete();
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, w1[i]);
      check($sformatf("cs%0d_in_chk", k), 64'({cpu_hold_o, done_o}), 64'b10);
      step(1'b0, 1'b1, (k == 0) ? 8'h22 : 8'h23);
      check($sformatf("cs%0d_status", k), 64'({done_o, err_o}),
            (k == 0) ? 64'b10 : 64'b11);
      check($sformatf("cs%0d_nwr", k), 64'(qa.size()), 64'd1);
      if (qa.size() == 1)
        check($sformatf("cs%0d_wr", k), 64'({qa[0], qd[0]}), 64'({11'd0, 32'hDEADBEEF}));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
